// File: rtl/low_priority_encoder_pkg.sv
// low_priority_encoder_pkg: shared sizes, code constants and the reference priority function.
// Optional feature macro used by the other files: LPE_MULTI_HOT_EN.
package low_priority_encoder_pkg;
    localparam int NUM_INPUTS = 4;
    localparam int CODE_W = 2;
    localparam logic [CODE_W-1:0] CODE_IN0 = 2'b00;
    localparam logic [CODE_W-1:0] CODE_IN1 = 2'b01;
    localparam logic [CODE_W-1:0] CODE_IN2 = 2'b10;
    localparam logic [CODE_W-1:0] CODE_IN3 = 2'b11;
    // Returns {valid, code}; bit 0 of the request vector has the highest priority.
    function automatic logic [CODE_W:0] lpe_encode(input logic [NUM_INPUTS-1:0] req);
        return req[0] ? {1'b1, CODE_IN0} :
               req[1] ? {1'b1, CODE_IN1} :
               req[2] ? {1'b1, CODE_IN2} :
               req[3] ? {1'b1, CODE_IN3} : {1'b0, CODE_IN0};
    endfunction
endpackage

// File: rtl/low_priority_encoder_if.sv
// low_priority_encoder_if: request inputs and registered encoder outputs.
// Signals: Data_0_In..Data_3_In (requests), Encoded_Value_Out, Valid_Out,
// Multi_Hot_Out (only when LPE_MULTI_HOT_EN is defined).
// Modports: master drives requests, slave (the encoder) drives results.
interface low_priority_encoder_if;
    import low_priority_encoder_pkg::*;
    logic              Data_0_In;
    logic              Data_1_In;
    logic              Data_2_In;
    logic              Data_3_In;
    logic [CODE_W-1:0] Encoded_Value_Out;
    logic              Valid_Out;
`ifdef LPE_MULTI_HOT_EN
    logic              Multi_Hot_Out;
    modport master (output Data_0_In, Data_1_In, Data_2_In, Data_3_In,
                    input  Encoded_Value_Out, Valid_Out, Multi_Hot_Out);
    modport slave  (input  Data_0_In, Data_1_In, Data_2_In, Data_3_In,
                    output Encoded_Value_Out, Valid_Out, Multi_Hot_Out);
`else
    modport master (output Data_0_In, Data_1_In, Data_2_In, Data_3_In,
                    input  Encoded_Value_Out, Valid_Out);
    modport slave  (input  Data_0_In, Data_1_In, Data_2_In, Data_3_In,
                    output Encoded_Value_Out, Valid_Out);
`endif
endinterface

// File: rtl/low_priority_encoder_4to2_core.sv
// low_priority_encoder_4to2_core: combinational lowest-index priority encoder.
// Ports: req (4-bit request vector), code (index of lowest set bit), valid (any bit set),
// multi_hot (two or more bits set; only when LPE_MULTI_HOT_EN is defined).
module low_priority_encoder_4to2_core
    import low_priority_encoder_pkg::*;
(
    input  logic [NUM_INPUTS-1:0] req,
    output logic [CODE_W-1:0]     code,
`ifdef LPE_MULTI_HOT_EN
    output logic                  multi_hot,
`endif
    output logic                  valid
);
    always_comb {valid, code} = lpe_encode(req);
`ifdef LPE_MULTI_HOT_EN
    // Clearing the lowest set bit leaves something only if more than one bit was set.
    always_comb multi_hot = (req & (req - 1'b1)) != '0;
`endif
endmodule

// File: rtl/low_priority_encoder_4to2.sv
// low_priority_encoder_4to2: registered 4-to-2 priority encoder, lowest index wins.
// Ports: Clock_In (rising-edge clock), Reset_In (synchronous, active-high),
// bus (slave modport: requests in, code/valid/optional multi-hot out, 1-cycle latency).
// Macro LPE_MULTI_HOT_EN adds the registered Multi_Hot_Out output.
module low_priority_encoder_4to2
    import low_priority_encoder_pkg::*;
(
    input  logic                  Clock_In,
    input  logic                  Reset_In,
    low_priority_encoder_if.slave bus
);
    logic [NUM_INPUTS-1:0] req;
    logic [CODE_W-1:0]     code;
    logic                  valid;
    always_comb req = {bus.Data_3_In, bus.Data_2_In, bus.Data_1_In, bus.Data_0_In};
`ifdef LPE_MULTI_HOT_EN
    logic multi_hot;
    low_priority_encoder_4to2_core u_core (.req(req), .code(code), .multi_hot(multi_hot), .valid(valid));
    always_ff @(posedge Clock_In)
        bus.Multi_Hot_Out <= Reset_In ? 1'b0 : multi_hot;
`else
    low_priority_encoder_4to2_core u_core (.req(req), .code(code), .valid(valid));
`endif
    // Reset branch never looks at the data, so unknown requests cannot leak out.
    always_ff @(posedge Clock_In)
        if (Reset_In) begin
            bus.Encoded_Value_Out <= CODE_IN0;
            bus.Valid_Out         <= 1'b0;
        end else begin
            bus.Encoded_Value_Out <= code;
            bus.Valid_Out         <= valid;
        end
endmodule

// File: tb/tb_low_priority_encoder_4to2.sv
// tb_low_priority_encoder_4to2: scoreboard bench for the registered lowest-index priority encoder.
module tb_low_priority_encoder_4to2;
    typedef struct packed {
        logic       m;
        logic       v;
        logic [1:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t q[$];
    exp_t e;
    exp_t got;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    low_priority_encoder_if bus();
    low_priority_encoder_4to2 dut (.Clock_In(clk), .Reset_In(rst), .bus(bus));

    // Independent reference: the last hit scanning from 3 down to 0 is the lowest index.
    function automatic exp_t model(input logic r, input logic [3:0] d);
        exp_t x;
        int n;
        x = '0;
        n = 0;
        if (r) return x;
        for (int i = 3; i >= 0; i--)
            if (d[i] === 1'b1) begin
                x.c = 2'(i);
                x.v = 1'b1;
                n++;
            end
`ifdef LPE_MULTI_HOT_EN
        x.m = n >= 2;
`endif
        return x;
    endfunction

    function automatic exp_t observed();
        exp_t x;
        x.c = bus.Encoded_Value_Out;
        x.v = bus.Valid_Out;
`ifdef LPE_MULTI_HOT_EN
        x.m = bus.Multi_Hot_Out;
`else
        x.m = 1'b0;
`endif
        return x;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, and stop just after the sampling edge.
    task automatic step(input logic r, input logic [3:0] d);
        @(negedge clk);
        rst = r;
        {bus.Data_3_In, bus.Data_2_In, bus.Data_1_In, bus.Data_0_In} = d;
        q.push_back(model(r, d));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 4'bxxxx);
            got = observed();
            e = q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset[%0d]: got m/v/code=%b/%b/%b want %b/%b/%b", k, got.m, got.v, got.c, e.m, e.v, e.c);
            end
        end
    endtask

    task automatic test_one_hot();
        logic [3:0] pat [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int k = 0; k < 4; k++) begin
            step(1'b0, pat[k]);
            got = observed();
            e = q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL one_hot %b: got m/v/code=%b/%b/%b want %b/%b/%b", pat[k], got.m, got.v, got.c, e.m, e.v, e.c);
            end
        end
    endtask

    task automatic test_priority();
        logic [3:0] pat [4] = '{4'b1111, 4'b1110, 4'b1100, 4'b1010};
        logic [1:0] want [4] = '{2'b00, 2'b01, 2'b10, 2'b01};
        for (int k = 0; k < 4; k++) begin
            step(1'b0, pat[k]);
            got = observed();
            e = q.pop_front();
            vectors++;
            if (got !== e || got.c !== want[k] || got.v !== 1'b1) begin
                miscompares++;
                $display("FAIL priority %b: got m/v/code=%b/%b/%b want %b/%b/%b", pat[k], got.m, got.v, got.c, e.m, e.v, want[k]);
            end
        end
    endtask

    task automatic test_idle();
        logic [3:0] pat [2] = '{4'b0000, 4'b1000};
        for (int k = 0; k < 2; k++) begin
            step(1'b0, pat[k]);
            got = observed();
            e = q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL idle %b: got m/v/code=%b/%b/%b want %b/%b/%b", pat[k], got.m, got.v, got.c, e.m, e.v, e.c);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic r [3] = '{1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            step(r[k], 4'b0100);
            got = observed();
            e = q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset_mid[%0d]: got m/v/code=%b/%b/%b want %b/%b/%b", k, got.m, got.v, got.c, e.m, e.v, e.c);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] d;
        for (int k = 0; k < 20; k++) begin
            d = 4'($urandom_range(0, 15));
            step(1'b0, d);
            got = observed();
            e = q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL random %b: got m/v/code=%b/%b/%b want %b/%b/%b", d, got.m, got.v, got.c, e.m, e.v, e.c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_one_hot();
        test_priority();
        test_idle();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
